// File: rtl/mmcm_drp_pkg.sv
// Shared types, FSM state codes and stored clock plans for the MMCME2_ADV DRP sequencer.
// DRP_VERIFY_EN adds the read-back verify states (VF_REQ / VF_WAIT).
package mmcm_drp_pkg;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE       = 4'd0;
    localparam state_t S_RST_ASSERT = 4'd1;
    localparam state_t S_RD_REQ     = 4'd2;
    localparam state_t S_RD_WAIT    = 4'd3;
    localparam state_t S_WR_REQ     = 4'd4;
    localparam state_t S_WR_WAIT    = 4'd5;
`ifdef DRP_VERIFY_EN
    localparam state_t S_VF_REQ     = 4'd6;
    localparam state_t S_VF_WAIT    = 4'd7;
`endif
    localparam state_t S_NEXT       = 4'd8;
    localparam state_t S_RELEASE    = 4'd9;
    localparam state_t S_LOCK_WAIT  = 4'd10;
    localparam state_t S_DONE       = 4'd11;
    localparam state_t S_ERROR      = 4'd12;

    // CLKOUT0..6 divides per plan; VCO fixed at 1000 MHz (200 MHz in, D=1, M=5).
    function automatic logic [5:0] plan_div(input logic [1:0] sel, input logic [2:0] n);
        logic [6:0][5:0] d;
        case (sel)
            2'd0:    d = {6'd50, 6'd25, 6'd5,  6'd8,  6'd40, 6'd20, 6'd10};
            2'd1:    d = {6'd16, 6'd40, 6'd8,  6'd4,  6'd20, 6'd10, 6'd5};
            2'd2:    d = {6'd5,  6'd8,  6'd25, 6'd50, 6'd20, 6'd10, 6'd40};
            default: d = {6'd8,  6'd50, 6'd25, 6'd40, 6'd5,  6'd10, 6'd20};
        endcase
        return (n < 3'd7) ? d[n] : 6'd1;
    endfunction

    function automatic logic [15:0] clk_reg1(input logic [5:0] div);
        logic [5:0] hi;
        logic [5:0] lo;
        hi = div >> 1;
        lo = div - hi;
        return {4'b0000, hi, lo};
    endfunction

    function automatic logic [15:0] clk_reg2(input logic [5:0] div);
        return {8'h00, div[0], div == 6'd1, 6'b000000};
    endfunction

    function automatic drp_entry_t cfg_entry(input logic [1:0] sel, input logic [4:0] idx);
        drp_entry_t e;
        logic [2:0] n;
        logic [6:0] base;
        logic [5:0] div;
        n = 3'((idx - 5'd1) >> 1);
        case (n)
            3'd0:    base = 7'h08;
            3'd1:    base = 7'h0A;
            3'd2:    base = 7'h0C;
            3'd3:    base = 7'h0E;
            3'd4:    base = 7'h10;
            3'd5:    base = 7'h06;
            default: base = 7'h12;
        endcase
        div = plan_div(sel, n);
        case (idx)
            5'd15:   e = '{7'h16, 16'hC000, 16'h1041};
            5'd16:   e = '{7'h14, 16'h1000, clk_reg1(6'd5)};
            5'd17:   e = '{7'h15, 16'hFC00, clk_reg2(6'd5)};
            5'd18:   e = '{7'h18, 16'hFC00, 16'h03E8};
            5'd19:   e = '{7'h19, 16'h8000, 16'h7C01};
            5'd20:   e = '{7'h1A, 16'h8000, 16'h7FE9};
            5'd21:   e = '{7'h4E, 16'h66FF, 16'h0900};
            5'd22:   e = '{7'h4F, 16'h666F, 16'h1000};
            default: begin
                if (idx != 5'd0 && idx <= 5'd14) begin
                    e.addr = idx[0] ? base : base + 7'd1;
                    e.mask = idx[0] ? 16'h1000 : 16'hFC00;
                    e.data = idx[0] ? clk_reg1(div) : clk_reg2(div);
                end else begin
                    e = '{7'h28, 16'h0000, 16'hFFFF};
                end
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mmcm_cfg_rom.sv
// Combinational DRP table lookup: (plan, entry index) -> address, keep-mask and data.
// Unaffected by DRP_VERIFY_EN.
module mmcm_cfg_rom
    import mmcm_drp_pkg::*;
(
    input  logic [1:0] sel_i,
    input  logic [4:0] idx_i,
    output drp_entry_t entry_o
);

    assign entry_o = cfg_entry(sel_i, idx_i);

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCME2_ADV DRP reconfiguration sequencer: hold MMCM in reset, read-modify-write a plan, wait LOCKED.
// Define DRP_VERIFY_EN to re-read every written register and fail on mismatch.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned NUM_CFG      = 4,
    parameter int unsigned REGS_PER_CFG = 23,
    parameter int unsigned DRP_TIMEOUT  = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    input  logic [$clog2(NUM_CFG)-1:0] cfg_sel,
    output logic                       cfg_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(NUM_CFG)-1:0] cur_cfg,
    output logic                       drp_den,
    output logic                       drp_dwe,
    output logic [6:0]                 drp_daddr,
    output logic [15:0]                drp_di,
    input  logic [15:0]                drp_do,
    input  logic                       drp_drdy,
    output logic                       mmcm_rst,
    input  logic                       mmcm_locked
);

    localparam int unsigned SEL_W = $clog2(NUM_CFG);
    localparam int unsigned IDX_W = $clog2(REGS_PER_CFG);
    localparam int unsigned TMR_W = $clog2(((LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT) + 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d, cur_cfg_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [15:0]        wdata_q, wdata_d, di_q;
    logic               seen_low_q, seen_low_d;
    logic               lock_meta_q, lock_sync_q;
    logic               err_q, den_q, dwe_q, mmcm_rst_q;
    logic [6:0]         daddr_q;
    logic               accept, issue;
    drp_entry_t         entry;

    mmcm_cfg_rom u_rom (
        .sel_i   (2'(sel_q)),
        .idx_i   (5'(idx_q)),
        .entry_o (entry)
    );

    assign accept    = (state_q == S_IDLE) && cfg_valid;
    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign cur_cfg   = cur_cfg_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign mmcm_rst  = mmcm_rst_q;

    always_comb begin
        issue = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
`ifdef DRP_VERIFY_EN
        issue = issue || (state_q == S_VF_REQ);
`endif
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        wdata_d    = wdata_q;
        seen_low_d = seen_low_q;
        case (state_q)
            S_IDLE: if (cfg_valid) begin
                sel_d   = cfg_sel;
                idx_d   = '0;
                state_d = S_RST_ASSERT;
            end
            S_RST_ASSERT: state_d = S_RD_REQ;
            S_RD_REQ: begin
                timer_d = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    wdata_d = (drp_do & entry.mask) | (entry.data & ~entry.mask);
                    state_d = S_WR_REQ;
                end else if (timer_q == TMR_W'(DRP_TIMEOUT)) state_d = S_ERROR;
                else timer_d = timer_q + 1'b1;
            end
            S_WR_REQ: begin
                timer_d = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
`ifdef DRP_VERIFY_EN
                    state_d = S_VF_REQ;
`else
                    state_d = S_NEXT;
`endif
                end else if (timer_q == TMR_W'(DRP_TIMEOUT)) state_d = S_ERROR;
                else timer_d = timer_q + 1'b1;
            end
`ifdef DRP_VERIFY_EN
            S_VF_REQ: begin
                timer_d = '0;
                state_d = S_VF_WAIT;
            end
            S_VF_WAIT: begin
                if (drp_drdy) state_d = ((drp_do ^ wdata_q) != '0) ? S_ERROR : S_NEXT;
                else if (timer_q == TMR_W'(DRP_TIMEOUT)) state_d = S_ERROR;
                else timer_d = timer_q + 1'b1;
            end
`endif
            S_NEXT: begin
                if (idx_q == IDX_W'(REGS_PER_CFG - 1)) state_d = S_RELEASE;
                else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RD_REQ;
                end
            end
            S_RELEASE: begin
                timer_d    = '0;
                seen_low_d = 1'b0;
                state_d    = S_LOCK_WAIT;
            end
            // LOCKED only counts once the synchroniser has been seen low after release.
            S_LOCK_WAIT: begin
                if (!lock_sync_q) seen_low_d = 1'b1;
                if (lock_sync_q && seen_low_q) state_d = S_DONE;
                else if (timer_q == TMR_W'(LOCK_TIMEOUT)) state_d = S_ERROR;
                else timer_d = timer_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST_ASSERT;
            sel_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            wdata_q     <= '0;
            seen_low_q  <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            err_q       <= 1'b0;
            cur_cfg_q   <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            mmcm_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            wdata_q     <= wdata_d;
            seen_low_q  <= seen_low_d;
            lock_meta_q <= mmcm_locked;
            lock_sync_q <= lock_meta_q;
            den_q       <= issue;
            dwe_q       <= (state_q == S_WR_REQ);
            if (issue) daddr_q <= entry.addr;
            if (state_q == S_WR_REQ) di_q <= wdata_q;
            if (accept) begin
                err_q      <= 1'b0;
                mmcm_rst_q <= 1'b1;
            end else if (state_d == S_ERROR) begin
                err_q      <= 1'b1;
                mmcm_rst_q <= 1'b1;
            end else if (state_q == S_RELEASE) begin
                mmcm_rst_q <= 1'b0;
            end
            if (state_d == S_DONE) cur_cfg_q <= sel_q;
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a DRP BFM and a simple LOCKED model.
// Build with DRP_VERIFY_EN defined to also exercise the read-back verify path.
module tb_mmcm_drp_reconfig;

`ifdef DRP_VERIFY_EN
    localparam int unsigned RD_PER_PLAN = 46;
`else
    localparam int unsigned RD_PER_PLAN = 23;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic        cfg_ready, busy, done, err;
    logic [1:0]  cur_cfg;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit hold_drdy = 1'b0;
    bit flip_rd = 1'b0;
    bit force_unlock = 1'b0;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(
        .NUM_CFG      (4),
        .REGS_PER_CFG (23),
        .DRP_TIMEOUT  (255),
        .LOCK_TIMEOUT (65535)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_sel     (cfg_sel),
        .cfg_ready   (cfg_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_cfg     (cur_cfg),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked)
    );

    // DRP BFM: register file initialised to 16'hFFFF, fixed response latency.
    logic [15:0] mem [128];
    bit          mem_init = 1'b0;
    int unsigned b_cnt = 0;
    logic [6:0]  b_addr = '0;
    logic        b_we = 1'b0;
    logic [15:0] b_di = '0;
    logic [15:0] wr08 = '0;
    int unsigned n_rd = 0, n_wr = 0, n_ovl = 0, n_acc = 0, n_rdybusy = 0;

    always @(posedge clk) begin
        drp_drdy <= 1'b0;
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 16'hFFFF;
            mem_init <= 1'b1;
        end
        if (cfg_valid && cfg_ready) n_acc <= n_acc + 1;
        if (cfg_ready && busy) n_rdybusy <= n_rdybusy + 1;
        if (!rst_n) begin
            b_cnt <= 0;
        end else if (drp_den) begin
            if (b_cnt != 0) n_ovl <= n_ovl + 1;
            b_addr <= drp_daddr;
            b_we   <= drp_dwe;
            b_di   <= drp_di;
            b_cnt  <= 3;
            if (drp_dwe) begin
                n_wr <= n_wr + 1;
                if (drp_daddr == 7'h08) wr08 <= drp_di;
            end else begin
                n_rd <= n_rd + 1;
            end
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1 && !hold_drdy) begin
                drp_drdy <= 1'b1;
                if (b_we) mem[b_addr] <= b_di;
                else drp_do <= mem[b_addr] ^ (flip_rd ? 16'h0001 : 16'h0000);
            end
        end
    end

    int unsigned lk_cnt = 0;
    always @(posedge clk) begin
        if (mmcm_rst || force_unlock) begin
            lk_cnt      <= 0;
            mmcm_locked <= 1'b0;
        end else if (lk_cnt < 20) begin
            lk_cnt <= lk_cnt + 1;
        end else begin
            mmcm_locked <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_cfg_ready"}, cfg_ready, 0);
        check({p, "_busy"}, busy, 1);
        check({p, "_done"}, done, 0);
        check({p, "_err"}, err, 0);
        check({p, "_cur_cfg"}, cur_cfg, 0);
        check({p, "_den"}, drp_den, 0);
        check({p, "_dwe"}, drp_dwe, 0);
        check({p, "_daddr"}, drp_daddr, 0);
        check({p, "_di"}, drp_di, 0);
        check({p, "_mmcm_rst"}, mmcm_rst, 1);
    endtask

    // which: 0 done, 1 err, 2 den, 3 mmcm_rst low
    task automatic wait_on(input int which, input int unsigned budget, output bit hit, output int unsigned cyc);
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = done;
                1:       hit = err;
                2:       hit = drp_den;
                default: hit = !mmcm_rst;
            endcase
        end
    endtask

    task automatic request(input logic [1:0] sel);
        @(negedge clk);
        cfg_sel   = sel;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        bit hit;
        int unsigned cyc, rd0, wr0, acc0, rb0;

        repeat (3) @(negedge clk);
        check_reset("rst");
        repeat (7) @(negedge clk);
        rd0 = n_rd;
        wr0 = n_wr;
        rst_n = 1'b1;
        wait_on(0, 3000, hit, cyc);
        check("t1_done", hit, 1);
        check("t1_cur_cfg", cur_cfg, 0);
        check("t1_reads", n_rd - rd0, RD_PER_PLAN);
        check("t1_writes", n_wr - wr0, 23);
        check("t1_clkout0_reg1", wr08, 16'h1145);
        check("t1_divclk", mem[7'h16], 16'hD041);
        check("t1_mmcm_rst", mmcm_rst, 0);
        check("t1_err", err, 0);

        request(2);
        wait_on(0, 3000, hit, cyc);
        check("t2_done", hit, 1);
        check("t2_cur_cfg", cur_cfg, 2);
        check("t2_clkout0_reg1", wr08, 16'h1514);
        check("t2_clkout4_reg1", mem[7'h10], 16'h130D);
        check("t2_busy_in_done", busy, 1);
        @(negedge clk);
        check("t2_done_pulse", done, 0);
        check("t2_busy_idle", busy, 0);
        check("t2_ready_idle", cfg_ready, 1);

        acc0 = n_acc;
        rb0  = n_rdybusy;
        @(negedge clk);
        cfg_sel   = 2'd1;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_sel = 2'd3;
        wait_on(0, 3000, hit, cyc);
        cfg_valid = 1'b0;
        check("t3_done", hit, 1);
        check("t3_accepts", n_acc - acc0, 1);
        check("t3_cur_cfg", cur_cfg, 1);
        check("t3_ready_while_busy", n_rdybusy - rb0, 0);
        @(negedge clk);
        check("t3_ready_after", cfg_ready, 1);

        hold_drdy = 1'b1;
        request(3);
        wait_on(2, 20, hit, cyc);
        check("t4_den", hit, 1);
        wait_on(1, 400, hit, cyc);
        check("t4_err", hit, 1);
        check("t4_timeout_cycles", cyc, 256);
        check("t4_busy", busy, 0);
        check("t4_mmcm_rst", mmcm_rst, 1);
        @(negedge clk);
        check("t4_err_sticky", err, 1);
        check("t4_cur_cfg_kept", cur_cfg, 1);
        hold_drdy = 1'b0;
        request(3);
        check("t4_err_cleared", err, 0);
        wait_on(0, 3000, hit, cyc);
        check("t4_recover_done", hit, 1);
        check("t4_recover_cur", cur_cfg, 3);

        force_unlock = 1'b1;
        request(0);
        wait_on(3, 3000, hit, cyc);
        check("t5_release", hit, 1);
        wait_on(1, 70000, hit, cyc);
        check("t5_err", hit, 1);
        check("t5_timeout_cycles", cyc, 65536);
        check("t5_mmcm_rst", mmcm_rst, 1);
        check("t5_cur_cfg_kept", cur_cfg, 3);
        force_unlock = 1'b0;
        request(1);
        wait_on(0, 3000, hit, cyc);
        check("t5_recover_done", hit, 1);
        check("t5_recover_cur", cur_cfg, 1);
        check("t5_recover_err", err, 0);

        wr0 = n_wr;
        request(2);
        hit = 1'b0;
        for (int unsigned i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            hit = (n_wr - wr0) >= 5;
        end
        check("t6_midseq", hit, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("t6");
        repeat (2) @(negedge clk);
        rd0 = n_rd;
        wr0 = n_wr;
        rst_n = 1'b1;
        wait_on(0, 3000, hit, cyc);
        check("t6_done", hit, 1);
        check("t6_cur_cfg", cur_cfg, 0);
        check("t6_writes", n_wr - wr0, 23);
        check("t6_reads", n_rd - rd0, RD_PER_PLAN);

`ifdef DRP_VERIFY_EN
        flip_rd = 1'b1;
        request(3);
        wait_on(1, 3000, hit, cyc);
        check("t7_verify_err", hit, 1);
        check("t7_mmcm_rst", mmcm_rst, 1);
        flip_rd = 1'b0;
        request(3);
        wait_on(0, 3000, hit, cyc);
        check("t7_recover_done", hit, 1);
        check("t7_recover_cur", cur_cfg, 3);
`endif

        check("den_overlap", n_ovl, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
